// File: rtl/bin_to_bcd_digits.sv
// bin_to_bcd_digits: sequential shift-and-add-3 binary to four BCD digits.
// Optional HEX_BYPASS_EN adds hex_mode to show raw nibbles without conversion.
module bin_to_bcd_digits #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
`ifdef HEX_BYPASS_EN
    input  logic             hex_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3
);
    localparam int SR_W = 16 + BIN_W;
    localparam int CW = $clog2(BIN_W);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     dig_q, dig_d;
    logic [15:0]     bcd_adj;
    logic [SR_W-1:0] sr_shift;
    logic            bin_big;

    assign bin_big = 32'(bin) > 32'd9999;

    // Add-3 correction on each BCD nibble before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[BIN_W+4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = sr_q[BIN_W+4*i +: 4];
        end
    end

    assign sr_shift = {bcd_adj[14:0], sr_q[BIN_W-1:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        dig_d      = dig_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d    = CONV;
                    sr_d       = SR_W'(bin);
                    cnt_d      = '0;
                    ovf_pend_d = bin_big;
`ifdef HEX_BYPASS_EN
                    if (hex_mode) begin
                        state_d    = DONE;
                        ovf_pend_d = 1'b0;
                        overflow_d = 1'b0;
                        dig_d      = 16'(bin);
                    end
`endif
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    overflow_d = ovf_pend_q;
                    dig_d      = ovf_pend_q ? 16'h9999 : sr_shift[SR_W-1 -: 16];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            dig_q      <= dig_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;
    assign d0       = dig_q[3:0];
    assign d1       = dig_q[7:4];
    assign d2       = dig_q[11:8];
    assign d3       = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// tb_bin_to_bcd_digits: directed table plus handshake/reset corner sequences.
// Define HEX_BYPASS_EN to also exercise the hex bypass path.
module tb_bin_to_bcd_digits;
    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin;
`ifdef HEX_BYPASS_EN
    logic             hex_mode;
`endif
    logic             busy, done, overflow;
    logic [3:0]       d0, d1, d2, d3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_digits #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
`ifdef HEX_BYPASS_EN
        .hex_mode (hex_mode),
`endif
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3)
    );

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [15:0]      dig;
        logic             ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digs();
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Start one conversion and wait (bounded) for done.
    task automatic run_conv(input logic [BIN_W-1:0] b, output int lat,
                            output int busy_n, output bit stable);
        logic [15:0] prev;
        prev   = digs();
        start  = 1'b1;
        bin    = b;
        tick();
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (digs() !== prev) stable = 1'b0;
            tick();
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, cnt;
        bit st;

        vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{14'd0,     16'h0000, 1'b0};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{14'd1,     16'h0001, 1'b0};
        vecs[5]  = '{14'd9,     16'h0009, 1'b0};
        vecs[6]  = '{14'd10,    16'h0010, 1'b0};
        vecs[7]  = '{14'd99,    16'h0099, 1'b0};
        vecs[8]  = '{14'd16383, 16'h9999, 1'b1};
        vecs[9]  = '{14'd100,   16'h0100, 1'b0};
        vecs[10] = '{14'd4095,  16'h4095, 1'b0};
        vecs[11] = '{14'd5678,  16'h5678, 1'b0};
        vecs[12] = '{14'd8191,  16'h8191, 1'b0};
        vecs[13] = '{14'd9998,  16'h9998, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
`ifdef HEX_BYPASS_EN
        hex_mode = 1'b0;
`endif
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_digits", 32'(digs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_conv(vecs[i].bin, lat, bn, st);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd15);
            check($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd14);
            check($sformatf("v%0d_stable", i), 32'(st), 32'd1);
            check($sformatf("v%0d_digits", i), 32'(digs()), 32'(vecs[i].dig));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd0);
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_ovf_hold", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Start during CONV ignored; start held through DONE restarts.
        start = 1'b1;
        bin   = 14'd42;
        tick();
        start = 1'b0;
        lat   = 1;
        repeat (4) begin
            tick();
            lat++;
        end
        start = 1'b1;
        bin   = 14'd777;
        tick();
        lat++;
        bin = 14'd42;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'd15);
        check("ignore_digits", 32'(digs()), 32'h0042);
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_spacing", 32'(lat), 32'd15);
        check("b2b_digits", 32'(digs()), 32'h0042);
        tick();

        // Async reset mid-conversion discards the result.
        run_conv(14'd12000, lat, bn, st);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        tick();
        start = 1'b1;
        bin   = 14'd5678;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_digits", 32'(digs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            tick();
            if (done || busy) cnt++;
        end
        check("no_done_after_rst", 32'(cnt), 32'd0);
        check("after_rst_digits", 32'(digs()), 32'd0);
        run_conv(14'd5678, lat, bn, st);
        check("after_rst_conv", 32'(digs()), 32'h5678);
        tick();

        // Display stays on old value until the new result lands.
        run_conv(14'd1234, lat, bn, st);
        check("stab_first", 32'(digs()), 32'h1234);
        tick();
        run_conv(14'd8, lat, bn, st);
        check("stab_hold", 32'(st), 32'd1);
        check("stab_latency", 32'(lat), 32'd15);
        check("stab_new", 32'(digs()), 32'h0008);
        tick();

`ifdef HEX_BYPASS_EN
        run_conv(14'd10001, lat, bn, st);
        tick();
        hex_mode = 1'b1;
        start    = 1'b1;
        bin      = 14'h3ABC;
        tick();
        start    = 1'b0;
        hex_mode = 1'b0;
        check("hex_done", 32'(done), 32'd1);
        check("hex_digits", 32'(digs()), 32'h3ABC);
        check("hex_ovf", 32'(overflow), 32'd0);
        tick();
        check("hex_done_pulse", 32'(done), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
